// File: rtl/synch_fifo_param.sv
// Parametrised single-clock FIFO: generic width/depth, programmable almost-full/empty
// thresholds, sticky overflow/underflow flags, registered or first-word-fall-through read.
module synch_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter bit FWFT      = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    data_avail,
  output logic [PTR_W:0]    room_avail,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              wr_acc;
  logic              rd_acc;

  // Status is a pure decode of the registered count, so it never depends on wr_en/rd_en.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign data_avail   = count;
  assign room_avail   = DEPTH_C - count;

  // A write into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      count     <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      overflow  <= (overflow  & ~clr_err) | (wr_en & ~wr_acc);
      underflow <= (underflow & ~clr_err) | (rd_en & ~rd_acc);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented directly; forced to zero while empty so no stale data leaks out.
      assign read_data  = empty ? '0 : mem[rd_ptr];
      assign read_valid = ~empty;
    end else begin : g_reg
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          read_data  <= '0;
          read_valid <= 1'b0;
        end else begin
          read_valid <= rd_acc;
          if (rd_acc) begin
            read_data <= mem[rd_ptr];
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_synch_fifo_param.sv
// Directed bench for synch_fifo_param: three instances (depth 8 registered, depth 6
// registered, depth 8 FWFT) share one stimulus stream and are checked per section.
module tb_synch_fifo_param;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] wd;
    logic [15:0] e_rdata;
    logic        e_rvalid;
    int          e_cnt;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] write_data = 16'h0;

  logic [15:0] rdata  [3];
  logic        rvalid [3];
  logic        full   [3];
  logic        empty  [3];
  logic        afull  [3];
  logic        aempty [3];
  logic [3:0]  davail [3];
  logic [3:0]  ravail [3];
  logic        ovf    [3];
  logic        unf    [3];

  int nCompared = 0;
  int nMismatched = 0;
  int depthOf [3] = '{8, 6, 8};
  vec_t vecs [$];

  always #5 clk = ~clk;

  synch_fifo_param #(.DATA_W(16), .DEPTH(8), .FWFT(1'b0)) dut8 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .write_data(write_data), .rd_en(rd_en),
    .read_data(rdata[0]), .read_valid(rvalid[0]), .full(full[0]), .empty(empty[0]),
    .almost_full(afull[0]), .almost_empty(aempty[0]), .data_avail(davail[0]),
    .room_avail(ravail[0]), .overflow(ovf[0]), .underflow(unf[0]), .clr_err(clr_err));

  synch_fifo_param #(.DATA_W(16), .DEPTH(6), .FWFT(1'b0)) dut6 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .write_data(write_data), .rd_en(rd_en),
    .read_data(rdata[1]), .read_valid(rvalid[1]), .full(full[1]), .empty(empty[1]),
    .almost_full(afull[1]), .almost_empty(aempty[1]), .data_avail(davail[1]),
    .room_avail(ravail[1]), .overflow(ovf[1]), .underflow(unf[1]), .clr_err(clr_err));

  synch_fifo_param #(.DATA_W(16), .DEPTH(8), .FWFT(1'b1)) dutf (
    .clk(clk), .reset(reset), .wr_en(wr_en), .write_data(write_data), .rd_en(rd_en),
    .read_data(rdata[2]), .read_valid(rvalid[2]), .full(full[2]), .empty(empty[2]),
    .almost_full(afull[2]), .almost_empty(aempty[2]), .data_avail(davail[2]),
    .room_avail(ravail[2]), .overflow(ovf[2]), .underflow(unf[2]), .clr_err(clr_err));

  function automatic vec_t mk(logic wr, logic rd, logic clr, logic [15:0] wd,
                              logic [15:0] e_rdata, logic e_rvalid, int e_cnt,
                              logic e_ovf, logic e_unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.wd = wd;
    v.e_rdata = e_rdata; v.e_rvalid = e_rvalid; v.e_cnt = e_cnt;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Flags are derived from the expected occupancy using default thresholds (DEPTH-1 and 1).
  task automatic checkOutput(input int idx, input string tag, input vec_t v);
    int d;
    d = depthOf[idx];
    if (!(idx == 2 && !v.e_rvalid)) cmp({tag, ".read_data"}, int'(rdata[idx]), int'(v.e_rdata));
    cmp({tag, ".read_valid"},   int'(rvalid[idx]), int'(v.e_rvalid));
    cmp({tag, ".data_avail"},   int'(davail[idx]), v.e_cnt);
    cmp({tag, ".room_avail"},   int'(ravail[idx]), d - v.e_cnt);
    cmp({tag, ".full"},         int'(full[idx]),   int'(v.e_cnt == d));
    cmp({tag, ".empty"},        int'(empty[idx]),  int'(v.e_cnt == 0));
    cmp({tag, ".almost_full"},  int'(afull[idx]),  int'(v.e_cnt >= d - 1));
    cmp({tag, ".almost_empty"}, int'(aempty[idx]), int'(v.e_cnt <= 1));
    cmp({tag, ".overflow"},     int'(ovf[idx]),    int'(v.e_ovf));
    cmp({tag, ".underflow"},    int'(unf[idx]),    int'(v.e_unf));
  endtask

  task automatic applyStimulus(input vec_t v);
    wr_en = v.wr;
    rd_en = v.rd;
    clr_err = v.clr;
    write_data = v.wd;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_err = 1'b0;
    write_data = 16'h0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vec_t rst_v;
    rst_v = mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0);

    // Reset values, checked while reset is still asserted
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) checkOutput(i, $sformatf("reset%0d", i), rst_v);
    reset = 1'b1;

    // Fill/drain, underflow and clear, full-FIFO overflow on the depth-8 registered FIFO
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, 0, 0, 16'(k), 16'h0, 0, k, 0, 0));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 1, 0, 16'h0, 16'(k), 1, 8 - k, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h8, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h0, 16'h8, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0, 16'h8, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0, 16'h8, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h0, 16'h8, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0, 16'h8, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) vecs.push_back(mk(1, 0, 0, 16'(16'h10 + k), 16'h8, 0, k + 1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h18, 16'h10, 1, 8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 16'h99, 16'h10, 0, 8, 1, 0));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(0, 1, 0, 16'h0, 16'(16'h10 + k), 1, 8 - k, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0, 16'h18, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 16'h55, 16'h18, 0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 16'h0, 16'h55, 1, 0, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(0, $sformatf("vec%0d", i), vecs[i]);
    end

    // Pointer wrap at steady occupancy 3, on power-of-2 and non-power-of-2 depths
    doReset();
    for (int k = 1; k <= 3; k++) begin
      vec_t v;
      v = mk(1, 0, 0, 16'(k), 16'h0, 0, k, 0, 0);
      applyStimulus(v);
      checkOutput(0, $sformatf("wrap_fill%0d_d8", k), v);
      checkOutput(1, $sformatf("wrap_fill%0d_d6", k), v);
    end
    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v = mk(1, 1, 0, 16'(4 + i), 16'(i + 1), 1, 3, 0, 0);
      applyStimulus(v);
      checkOutput(0, $sformatf("wrap_pair%0d_d8", i), v);
      checkOutput(1, $sformatf("wrap_pair%0d_d6", i), v);
    end
    for (int k = 0; k < 3; k++) begin
      vec_t v;
      v = mk(0, 1, 0, 16'h0, 16'(21 + k), 1, 2 - k, 0, 0);
      applyStimulus(v);
      checkOutput(0, $sformatf("wrap_drain%0d_d8", k), v);
      checkOutput(1, $sformatf("wrap_drain%0d_d6", k), v);
    end

    // First-word-fall-through: data visible without rd_en, pop empties it
    doReset();
    applyStimulus(mk(1, 0, 0, 16'hBEEF, 16'h0, 0, 0, 0, 0));
    checkOutput(2, "fwft_write", mk(0, 0, 0, 16'h0, 16'hBEEF, 1, 1, 0, 0));
    applyStimulus(mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));
    checkOutput(2, "fwft_hold", mk(0, 0, 0, 16'h0, 16'hBEEF, 1, 1, 0, 0));
    applyStimulus(mk(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0));
    checkOutput(2, "fwft_pop", mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of a write burst
    doReset();
    for (int k = 0; k < 5; k++) begin
      vec_t v;
      v = mk(1, 0, 0, 16'(16'hA0 + k), 16'h0, 0, k + 1, 0, 0);
      applyStimulus(v);
      checkOutput(0, $sformatf("mid_fill%0d", k), v);
    end
    wr_en = 1'b1;
    write_data = 16'hA5;
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) checkOutput(i, $sformatf("mid_reset%0d", i), rst_v);
    @(posedge clk);
    #1;
    checkOutput(0, "mid_reset_held", rst_v);
    wr_en = 1'b0;
    reset = 1'b1;
    applyStimulus(mk(1, 0, 0, 16'h1234, 16'h0, 0, 0, 0, 0));
    checkOutput(0, "post_reset_write", mk(0, 0, 0, 16'h0, 16'h0, 0, 1, 0, 0));
    checkOutput(2, "post_reset_write_fwft", mk(0, 0, 0, 16'h0, 16'h1234, 1, 1, 0, 0));
    applyStimulus(mk(0, 1, 0, 16'h0, 16'h0, 0, 0, 0, 0));
    checkOutput(0, "post_reset_read", mk(0, 0, 0, 16'h0, 16'h1234, 1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
